// File: rtl/jtvigil_gfx_arb.sv
// jtvigil_gfx_arb
// Shares one SDRAM read port among the scroll 1, scroll 2 and object ROM
// fetchers. Arbitration is round-robin with a single outstanding request.
// Each requester has a one-entry tag cache, so a requester that holds its
// address steady keeps getting ok without another SDRAM read.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   LHBL                   horizontal blank (active low), optional feature only
//   scrN_/obj_ cs/addr     fetch request and word address per requester
//   scrN_/obj_ data/ok     cached word and its validity for the current address
//   sdram_req/addr         read request towards the SDRAM controller
//   sdram_ack/dst/data     request accepted, read strobe, read data
//
// Optional feature: define JTVIGIL_ARB_OBJPRIO_EN to give obj fixed top
// priority while LHBL is low (pointer still updated as usual).
module jtvigil_gfx_arb #(
  parameter logic [21:0] SCR1_OFFSET = 22'h00000,
  parameter logic [21:0] SCR2_OFFSET = 22'h20000,
  parameter logic [21:0] OBJ_OFFSET  = 22'h60000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        LHBL,
  input  logic        scr1_cs,
  input  logic [16:0] scr1_addr,
  output logic [31:0] scr1_data,
  output logic        scr1_ok,
  input  logic        scr2_cs,
  input  logic [17:0] scr2_addr,
  output logic [31:0] scr2_data,
  output logic        scr2_ok,
  input  logic        obj_cs,
  input  logic [17:0] obj_addr,
  output logic [31:0] obj_data,
  output logic        obj_ok,
  output logic        sdram_req,
  output logic [21:0] sdram_addr,
  input  logic        sdram_ack,
  input  logic        sdram_dst,
  input  logic [31:0] sdram_data
);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DST} state_t;

  // Requester index: 0 = scr1, 1 = scr2, 2 = obj
  state_t            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [17:0]       snap_q, snap_d;
  logic [2:0][17:0]  tag_q, tag_d;
  logic [2:0][31:0]  data_q, data_d;
  logic [2:0]        valid_q, valid_d;
  logic [2:0]        ok_q, ok_d;
  logic              req_q, req_d;
  logic [21:0]       addr_q, addr_d;

  logic [2:0][17:0]  addr_x;
  logic [2:0][21:0]  offs;
  logic [2:0]        cs_x, hit, pend;
  logic [1:0]        pick;
  logic              pick_v;
  logic              cap;
  logic [2:0]        idx;

`ifndef JTVIGIL_ARB_OBJPRIO_EN
  logic unused_lhbl;
  assign unused_lhbl = LHBL;
`endif

  always_comb begin
    addr_x  = {obj_addr, scr2_addr, {1'b0, scr1_addr}};
    offs    = {OBJ_OFFSET, SCR2_OFFSET, SCR1_OFFSET};
    cs_x    = {obj_cs, scr2_cs, scr1_cs};
    for (int i = 0; i < 3; i++) begin
      hit[i]  = valid_q[i] & (addr_x[i] == tag_q[i]);
      pend[i] = cs_x[i] & ~hit[i];
    end

    // First pending requester after the pointer
    pick   = 2'd0;
    pick_v = 1'b0;
    idx    = 3'd0;
    for (int k = 1; k <= 3; k++) begin
      idx = {1'b0, ptr_q} + k[2:0];
      if (idx >= 3'd3) idx = idx - 3'd3;
      if (!pick_v && pend[idx[1:0]]) begin
        pick   = idx[1:0];
        pick_v = 1'b1;
      end
    end
`ifdef JTVIGIL_ARB_OBJPRIO_EN
    if (!LHBL && pend[2]) begin
      pick   = 2'd2;
      pick_v = 1'b1;
    end
`endif

    // Return data can arrive together with the ack
    cap = sdram_dst & ((state_q == WAIT_DST) | ((state_q == WAIT_ACK) & sdram_ack));

    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    snap_d  = snap_q;
    tag_d   = tag_q;
    data_d  = data_q;
    valid_d = valid_q;
    req_d   = req_q;
    addr_d  = addr_q;

    // Bypass the word being written so ok rises right after the dst cycle
    for (int i = 0; i < 3; i++)
      ok_d[i] = cs_x[i] & ((cap && gnt_q == i[1:0]) ? (addr_x[i] == snap_q) : hit[i]);

    case (state_q)
      IDLE: begin
        if (pick_v) begin
          gnt_d   = pick;
          snap_d  = addr_x[pick];
          addr_d  = offs[pick] + {4'd0, addr_x[pick]};
          req_d   = 1'b1;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (sdram_ack) begin
          req_d   = 1'b0;
          state_d = WAIT_DST;
        end
      end
      WAIT_DST: ;
      default: state_d = IDLE;
    endcase

    if (cap) begin
      data_d[gnt_q]  = sdram_data;
      tag_d[gnt_q]   = snap_q;
      valid_d[gnt_q] = 1'b1;
      ptr_d          = gnt_q;
      state_d        = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd2;
      gnt_q   <= 2'd0;
      snap_q  <= '0;
      tag_q   <= '0;
      data_q  <= '0;
      valid_q <= '0;
      ok_q    <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      snap_q  <= snap_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ok_q    <= ok_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

  assign scr1_data  = data_q[0];
  assign scr2_data  = data_q[1];
  assign obj_data   = data_q[2];
  assign scr1_ok    = ok_q[0];
  assign scr2_ok    = ok_q[1];
  assign obj_ok     = ok_q[2];
  assign sdram_req  = req_q;
  assign sdram_addr = addr_q;

endmodule

// File: tb/tb_jtvigil_gfx_arb.sv
// Bench for jtvigil_gfx_arb: directed scenarios with literal expectations,
// then randomized traffic, all outputs compared every cycle against a
// transaction-level model of the arbiter.
module tb_jtvigil_gfx_arb;
  logic        clk = 0, rst_n = 0, LHBL = 1;
  logic        scr1_cs = 0, scr2_cs = 0, obj_cs = 0;
  logic [16:0] scr1_addr = 0;
  logic [17:0] scr2_addr = 0, obj_addr = 0;
  logic        sdram_ack = 0, sdram_dst = 0;
  logic [31:0] sdram_data = 0;
  wire  [31:0] scr1_data, scr2_data, obj_data;
  wire         scr1_ok, scr2_ok, obj_ok, sdram_req;
  wire  [21:0] sdram_addr;

  jtvigil_gfx_arb dut (
    .clk(clk), .rst_n(rst_n), .LHBL(LHBL),
    .scr1_cs(scr1_cs), .scr1_addr(scr1_addr), .scr1_data(scr1_data), .scr1_ok(scr1_ok),
    .scr2_cs(scr2_cs), .scr2_addr(scr2_addr), .scr2_data(scr2_data), .scr2_ok(scr2_ok),
    .obj_cs(obj_cs), .obj_addr(obj_addr), .obj_data(obj_data), .obj_ok(obj_ok),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
    .sdram_dst(sdram_dst), .sdram_data(sdram_data));

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          OFF[3] = '{32'h00000, 32'h20000, 32'h60000};
  int          m_phase = 0;      // 0 idle, 1 request out, 2 awaiting data
  int          m_ptr = 2, m_g = 0;
  logic [17:0] m_snap = 0;
  logic [17:0] m_tag[3];
  logic [31:0] m_data[3];
  bit          m_valid[3];
  bit          e_ok[3];
  logic        e_req = 0;
  logic [21:0] e_addr = 0;
  bit          started = 0;

  function automatic logic [17:0] a_of(int i);
    return (i == 0) ? {1'b0, scr1_addr} : (i == 1) ? scr2_addr : obj_addr;
  endfunction
  function automatic bit cs_of(int i);
    return (i == 0) ? scr1_cs : (i == 1) ? scr2_cs : obj_cs;
  endfunction

  always @(posedge clk) begin : model
    bit hit[3];
    bit cap;
    int pick;
    for (int i = 0; i < 3; i++) hit[i] = m_valid[i] && (a_of(i) == m_tag[i]);
    if (!rst_n) begin
      m_phase = 0; m_ptr = 2; e_req = 0; e_addr = 0;
      for (int i = 0; i < 3; i++) begin
        m_valid[i] = 0; m_data[i] = 0; m_tag[i] = 0; e_ok[i] = 0;
      end
    end else begin
      cap = sdram_dst && (m_phase == 2 || (m_phase == 1 && sdram_ack));
      for (int i = 0; i < 3; i++)
        e_ok[i] = cs_of(i) && ((cap && m_g == i) ? (a_of(i) == m_snap) : hit[i]);
      if (cap) begin
        m_data[m_g] = sdram_data; m_tag[m_g] = m_snap; m_valid[m_g] = 1;
        m_ptr = m_g; m_phase = 0; e_req = 0;
      end else if (m_phase == 1 && sdram_ack) begin
        m_phase = 2; e_req = 0;
      end else if (m_phase == 0) begin
        pick = -1;
        for (int k = 1; k <= 3; k++)
          if (pick < 0 && cs_of((m_ptr + k) % 3) && !hit[(m_ptr + k) % 3]) pick = (m_ptr + k) % 3;
`ifdef JTVIGIL_ARB_OBJPRIO_EN
        if (!LHBL && cs_of(2) && !hit[2]) pick = 2;
`endif
        if (pick >= 0) begin
          m_g = pick; m_snap = a_of(pick);
          e_addr = 22'((OFF[pick] + int'(a_of(pick))) % (1 << 22));
          e_req = 1; m_phase = 1;
        end
      end
    end
    started = 1;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (started) begin
      chk("sdram_req", {31'd0, sdram_req}, {31'd0, e_req});
      chk("sdram_addr", {10'd0, sdram_addr}, {10'd0, e_addr});
      chk("scr1_ok", {31'd0, scr1_ok}, {31'd0, e_ok[0]});
      chk("scr2_ok", {31'd0, scr2_ok}, {31'd0, e_ok[1]});
      chk("obj_ok", {31'd0, obj_ok}, {31'd0, e_ok[2]});
      chk("scr1_data", scr1_data, m_data[0]);
      chk("scr2_data", scr2_data, m_data[1]);
      chk("obj_data", obj_data, m_data[2]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic serve(input int ad, input int dd, input logic [31:0] d);
    repeat (ad) tick();
    sdram_ack = 1; tick(); sdram_ack = 0;
    repeat (dd) tick();
    sdram_dst = 1; sdram_data = d; tick(); sdram_dst = 0;
  endtask

  initial begin
    // Reset with everything requesting
    rst_n = 0; scr1_cs = 1; scr2_cs = 1; obj_cs = 1;
    scr1_addr = 17'h00123; scr2_addr = 18'h00456; obj_addr = 18'h00789;
    repeat (4) begin
      tick();
      chk("rst_req", {31'd0, sdram_req}, 0);
      chk("rst_ok", {29'd0, scr1_ok, scr2_ok, obj_ok}, 0);
    end
    rst_n = 1;
    tick();
    chk("first_req", {31'd0, sdram_req}, 1);
    chk("first_addr", {10'd0, sdram_addr}, 32'h00123);
    serve(1, 2, 32'hA0000001);
    chk("scr1_ok_after", {31'd0, scr1_ok}, 1);
    chk("scr1_data_after", scr1_data, 32'hA0000001);
    tick();
    chk("rr_scr2_addr", {10'd0, sdram_addr}, 32'h20456);
    serve(0, 0, 32'hA0000002);
    tick();
    chk("rr_obj_addr", {10'd0, sdram_addr}, 32'h60789);
    serve(2, 1, 32'hA0000003);
    chk("all_ok", {29'd0, scr1_ok, scr2_ok, obj_ok}, 32'h7);
    scr1_addr = 17'h00124;
    tick();
    chk("scr1_ok_fall", {31'd0, scr1_ok}, 0);
    chk("rr_scr1_again", {10'd0, sdram_addr}, 32'h00124);
    serve(1, 1, 32'hA0000004);

    // Single scr2 read
    scr1_cs = 0; obj_cs = 0; scr2_addr = 18'h00010;
    tick();
    chk("scr2_addr", {10'd0, sdram_addr}, 32'h20010);
    serve(3, 5, 32'hDEADBEEF);
    chk("scr2_ok", {31'd0, scr2_ok}, 1);
    chk("scr2_data", scr2_data, 32'hDEADBEEF);
    repeat (5) begin
      tick();
      chk("no_refetch", {31'd0, sdram_req}, 0);
    end

    // Address change mid-fetch
    scr2_cs = 0; obj_cs = 1; obj_addr = 18'h00100;
    tick();
    chk("obj_addr100", {10'd0, sdram_addr}, 32'h60100);
    tick(); sdram_ack = 1; tick(); sdram_ack = 0; obj_addr = 18'h00101;
    tick(); sdram_dst = 1; sdram_data = 32'h11111111; tick(); sdram_dst = 0;
    chk("obj_ok_stale", {31'd0, obj_ok}, 0);
    chk("obj_data_stale", obj_data, 32'h11111111);
    tick();
    chk("obj_addr101", {10'd0, sdram_addr}, 32'h60101);
    serve(1, 1, 32'h22222222);
    chk("obj_ok101", {31'd0, obj_ok}, 1);

    // Same-cycle ack and dst
    obj_addr = 18'h00200;
    tick();
    chk("obj_addr200", {10'd0, sdram_addr}, 32'h60200);
    sdram_ack = 1; sdram_dst = 1; sdram_data = 32'h33333333;
    tick(); sdram_ack = 0; sdram_dst = 0;
    chk("ackdst_ok", {31'd0, obj_ok}, 1);
    chk("ackdst_req", {31'd0, sdram_req}, 0);
    tick();
    chk("ackdst_idle", {31'd0, sdram_req}, 0);

    // Pointer at obj; LHBL low with scr1 and obj pending
    scr1_cs = 1; scr1_addr = 17'h000AA; obj_addr = 18'h00300; LHBL = 0;
    tick();
`ifdef JTVIGIL_ARB_OBJPRIO_EN
    chk("prio_first", {10'd0, sdram_addr}, 32'h60300);
`else
    chk("prio_first", {10'd0, sdram_addr}, 32'h000AA);
`endif
    serve(0, 1, 32'h44444444);
    tick();
    serve(0, 1, 32'h55555555);
    LHBL = 1;

    // Reset mid-transfer, then a late dst
    scr1_cs = 0; obj_cs = 0; scr2_cs = 1; scr2_addr = 18'h00055;
    tick();
    chk("mid_req", {31'd0, sdram_req}, 1);
    rst_n = 0; tick();
    chk("mid_rst_req", {31'd0, sdram_req}, 0);
    rst_n = 1; scr2_cs = 0; sdram_dst = 1; sdram_data = 32'h66666666;
    tick(); sdram_dst = 0;
    chk("late_dst_ok", {31'd0, scr2_ok}, 0);
    chk("late_dst_data", scr2_data, 0);
    tick();
    chk("late_dst_req", {31'd0, sdram_req}, 0);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 9) == 0) scr1_cs = ~scr1_cs;
      if ($urandom_range(0, 9) == 0) scr2_cs = ~scr2_cs;
      if ($urandom_range(0, 9) == 0) obj_cs = ~obj_cs;
      if ($urandom_range(0, 19) == 0) scr1_addr = 17'($urandom_range(0, 3)) | (($urandom_range(0, 7) == 0) ? 17'h1FFF0 : 17'h0);
      if ($urandom_range(0, 19) == 0) scr2_addr = 18'($urandom_range(0, 3)) | (($urandom_range(0, 7) == 0) ? 18'h3FFF0 : 18'h0);
      if ($urandom_range(0, 19) == 0) obj_addr = 18'($urandom_range(0, 3)) | (($urandom_range(0, 7) == 0) ? 18'h3FFF0 : 18'h0);
      if ($urandom_range(0, 15) == 0) LHBL = ~LHBL;
      sdram_ack = (m_phase == 1) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 29) == 0);
      if (m_phase == 2) sdram_dst = $urandom_range(0, 9) < 3;
      else if (m_phase == 1 && sdram_ack) sdram_dst = $urandom_range(0, 9) < 2;
      else sdram_dst = $urandom_range(0, 29) == 0;
      sdram_data = $urandom;
      rst_n = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst_n = 1; sdram_ack = 0; sdram_dst = 0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/jtvigil_gfx_arb.md
Name: jtvigil_gfx_arb

Overview:
- Shares one SDRAM read port among the three video ROM fetchers: scroll 1, scroll 2 and objects.
- Sits between the video block's scr1/scr2/obj rom_addr/rom_cs/rom_data/rom_ok buses and the SDRAM controller.
- Round-robin arbitration, one outstanding request, one-entry tag cache per requester.
- A requester holding a stable address gets ok without a refetch.

Parameters:
SCR1_OFFSET, 22'h00000, SDRAM word offset added to scr1 address
SCR2_OFFSET, 22'h20000, SDRAM word offset added to scr2 address
OBJ_OFFSET, 22'h60000, SDRAM word offset added to obj address

Ports:
clk  in  1  system clock (48 MHz)
rst_n  in  1  synchronous active-low reset
LHBL  in  1  horizontal blank, active low (used only with optional feature)
scr1_cs  in  1  scroll 1 fetch request
scr1_addr  in  17  scroll 1 word address
scr1_data  out  32  scroll 1 fetched word
scr1_ok  out  1  scr1_data valid for current scr1_addr
scr2_cs  in  1  scroll 2 fetch request
scr2_addr  in  18  scroll 2 word address
scr2_data  out  32  scroll 2 fetched word
scr2_ok  out  1  scr2_data valid for current scr2_addr
obj_cs  in  1  object fetch request
obj_addr  in  18  object word address
obj_data  out  32  object fetched word
obj_ok  out  1  obj_data valid for current obj_addr
sdram_req  out  1  SDRAM read request
sdram_addr  out  22  SDRAM word address
sdram_ack  in  1  request accepted
sdram_dst  in  1  read data strobe
sdram_data  in  32  read data

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values:
  - All *_ok = 0, all *_data = 0.
  - sdram_req = 0, sdram_addr = 0.
  - State = IDLE; round-robin pointer = obj, so scr1 is checked first.
  - All cache valid bits cleared.
- Reset mid-transfer: the transfer is abandoned, sdram_req drops next cycle, and any late dst is ignored.
- Per requester i, each cache entry holds tag_i, data_i and valid_i.
  - hit_i = valid_i & (addr_i == tag_i).
  - pend_i = cs_i & ~hit_i.
- Output timing:
  - ok_i is registered: ok_i <= cs_i & hit_i.
  - *_data is driven from data_i.
  - ok_i falls one cycle after cs_i falls or addr_i changes.
  - The cache is retained while cs_i is low.
- State machine:
  - IDLE: if any pend_i, grant the first pending requester after the pointer in the order scr1 -> scr2 -> obj -> scr1. Latch the grant and the address snapshot. Set sdram_addr = OFFSET_i + zero-extended addr_i (modulo 2^22). Assert sdram_req and go to WAIT_ACK.
  - WAIT_ACK: sdram_req stays high and sdram_addr is held. On sdram_ack, sdram_req drops next cycle and the state goes to WAIT_DST.
  - WAIT_DST: on sdram_dst, store sdram_data into data_i, the snapshot into tag_i, set valid_i, set the pointer to the granted requester, and return to IDLE.
- Throughput:
  - A hit on a returned word raises ok one cycle after the dst cycle.
  - The earliest next grant is the cycle after returning to IDLE.
- Simultaneous ack and dst in WAIT_ACK: both are processed. Data is captured and the state goes directly to IDLE.
- dst in IDLE or in WAIT_ACK without ack is ignored.
- Address change during a fetch: the fetch completes and is stored under the snapshot tag. ok stays low for the new address, which is refetched on a later grant.
- cs dropped during a fetch: the fetch completes and the cache is updated; ok stays 0.
- Fairness: at most 2 other grants can occur between a requester going pending and being granted.

Optional Feature:
- Macro: JTVIGIL_ARB_OBJPRIO_EN.
- Defined: while LHBL = 0, obj has fixed top priority in IDLE, overriding round-robin. The pointer is still updated as normal.
- Undefined: LHBL is ignored and arbitration is pure round-robin.

Test Plan:
- Reset sequence: hold rst_n=0 for 4 clk with all cs=1 -> sdram_req=0 and all ok=0 throughout; first sdram_req appears with sdram_addr=22'h00000+scr1_addr.
- Single scr2 read: scr2_cs=1, scr2_addr=18'h00010, ack after 3 clk, dst with 32'hDEADBEEF after 5 more clk -> sdram_addr=22'h20010, scr2_data=32'hDEADBEEF, scr2_ok=1 the cycle after dst; addr held -> no further sdram_req.
- All three pending with distinct addresses -> grants in order scr1, scr2, obj; then new scr1 address -> scr1 granted next.
- Address change mid-fetch: obj_addr 0x100 changed to 0x101 before dst -> obj_ok stays 0, second request at 22'h60101, obj_ok=1 after its dst.
- Same-cycle ack and dst: ack=dst=1 on cycle 1 of WAIT_ACK -> data captured, IDLE next cycle, no hang.
- With JTVIGIL_ARB_OBJPRIO_EN defined: LHBL=0 with scr1 and obj pending, pointer favouring scr1 -> obj granted first; with LHBL=1 -> scr1 granted first.
